// File: rtl/wb_pkg.sv
// Shared types and constants for the register-file write-back path.
package wb_pkg;

  localparam int XLEN       = 64;
  localparam int REG_ADDR_W = 5;
  localparam int NREGS      = 32;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       data;
  } wb_req_t;

  typedef enum logic {
    WB_SRC_EX  = 1'b0,
    WB_SRC_MEM = 1'b1
  } wb_src_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter; the pointer remembers who was granted last.
module rr_arb2
  import wb_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] gnt
);

  wb_src_e r_last;

  // Last-granted pointer; reset value lets mem win the first conflict.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_last <= WB_SRC_EX;
    end else if (advance) begin
      r_last <= gnt[WB_SRC_MEM] ? WB_SRC_MEM : WB_SRC_EX;
    end else begin
      r_last <= r_last;
    end
  end

  // Grant selection; nothing is granted while reset is held.
  always_comb begin
    gnt = 2'b00;
    if (!rst) begin
      gnt = 2'b00;
    end else if (req == 2'b11) begin
      gnt = (r_last == WB_SRC_EX) ? 2'b10 : 2'b01;
    end else begin
      gnt = req;
    end
  end

endmodule

// File: rtl/regfile_writeback.sv
// Write-back arbiter, registered write port and pending-write scoreboard.
// Optional same-cycle forwarding from the write port: define REGFILE_WB_FWD_EN.
module regfile_writeback
  import wb_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  iss_valid,
  input  logic [REG_ADDR_W-1:0] iss_rd,
  output logic [NREGS-1:0]      busy,
  input  logic                  ex_valid,
  output logic                  ex_ready,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic [XLEN-1:0]       ex_data,
  input  logic                  mem_valid,
  output logic                  mem_ready,
  input  logic [REG_ADDR_W-1:0] mem_rd,
  input  logic [XLEN-1:0]       mem_data,
  output logic                  we,
  output logic [REG_ADDR_W-1:0] wr_addr,
  output logic [XLEN-1:0]       wr_data,
  input  logic [REG_ADDR_W-1:0] rs1_addr,
  input  logic [REG_ADDR_W-1:0] rs2_addr,
  output logic                  fwd_hit_0,
  output logic                  fwd_hit_1,
  output logic [XLEN-1:0]       fwd_data_0,
  output logic [XLEN-1:0]       fwd_data_1
);

  logic [1:0]            w_req;
  logic [1:0]            w_gnt;
  logic                  w_adv;
  wb_req_t               w_sel;
  logic [NREGS-1:0]      w_busy_nxt;
  logic                  r_we;
  logic [REG_ADDR_W-1:0] r_wr_addr;
  logic [XLEN-1:0]       r_wr_data;
  logic [NREGS-1:0]      r_busy;

  assign w_req = {mem_valid, ex_valid};

  rr_arb2 u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (w_req),
    .advance (w_adv),
    .gnt     (w_gnt)
  );

  assign w_adv     = |w_gnt;
  assign ex_ready  = w_gnt[WB_SRC_EX];
  assign mem_ready = w_gnt[WB_SRC_MEM];

  // Mux the granted request onto the write path.
  always_comb begin
    w_sel = '0;
    if (w_gnt[WB_SRC_MEM]) begin
      w_sel.rd   = mem_rd;
      w_sel.data = mem_data;
    end else begin
      w_sel.rd   = ex_rd;
      w_sel.data = ex_data;
    end
  end

  // Scoreboard next state: clear on granted write, then set on issue so set wins.
  always_comb begin
    w_busy_nxt = r_busy;
    if (w_adv) begin
      w_busy_nxt[w_sel.rd] = 1'b0;
    end else begin
      w_busy_nxt = r_busy;
    end
    if (iss_valid && (iss_rd != 5'd0)) begin
      w_busy_nxt[iss_rd] = 1'b1;
    end else begin
      w_busy_nxt[0] = 1'b0;
    end
    w_busy_nxt[0] = 1'b0;
  end

  // Registered write port and scoreboard; x0 writes complete but never assert we.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_we      <= 1'b0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
      r_busy    <= '0;
    end else begin
      r_we   <= w_adv && (w_sel.rd != 5'd0);
      r_busy <= w_busy_nxt;
      if (w_adv && (w_sel.rd != 5'd0)) begin
        r_wr_addr <= w_sel.rd;
        r_wr_data <= w_sel.data;
      end else begin
        r_wr_addr <= r_wr_addr;
        r_wr_data <= r_wr_data;
      end
    end
  end

  assign we      = r_we;
  assign wr_addr = r_wr_addr;
  assign wr_data = r_wr_data;
  assign busy    = r_busy;

`ifdef REGFILE_WB_FWD_EN
  // Bypass the value currently on the write port to same-cycle readers.
  always_comb begin
    fwd_hit_0  = 1'b0;
    fwd_hit_1  = 1'b0;
    fwd_data_0 = '0;
    fwd_data_1 = '0;
    if (r_we && (r_wr_addr != 5'd0) && (r_wr_addr == rs1_addr)) begin
      fwd_hit_0  = 1'b1;
      fwd_data_0 = r_wr_data;
    end else begin
      fwd_hit_0  = 1'b0;
    end
    if (r_we && (r_wr_addr != 5'd0) && (r_wr_addr == rs2_addr)) begin
      fwd_hit_1  = 1'b1;
      fwd_data_1 = r_wr_data;
    end else begin
      fwd_hit_1  = 1'b0;
    end
  end
`else
  logic w_unused_rs;
  assign w_unused_rs = ^{rs1_addr, rs2_addr};
  assign fwd_hit_0   = 1'b0;
  assign fwd_hit_1   = 1'b0;
  assign fwd_data_0  = '0;
  assign fwd_data_1  = '0;
`endif

endmodule

// File: tb/tb_regfile_writeback.sv
// Directed self-checking bench for regfile_writeback.
module tb_regfile_writeback;
  import wb_pkg::*;

  logic            clk = 1'b0;
  logic            rst;
  logic            iss_valid;
  logic [4:0]      iss_rd;
  logic [31:0]     busy;
  logic            ex_valid, ex_ready, mem_valid, mem_ready;
  logic [4:0]      ex_rd, mem_rd, rs1_addr, rs2_addr, wr_addr;
  logic [63:0]     ex_data, mem_data, wr_data, fwd_data_0, fwd_data_1;
  logic            we, fwd_hit_0, fwd_hit_1;
  int              n_total = 0;
  int              n_bad   = 0;

  always #5 clk = ~clk;

  regfile_writeback dut (
    .clk(clk), .rst(rst), .iss_valid(iss_valid), .iss_rd(iss_rd), .busy(busy),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_rd(ex_rd), .ex_data(ex_data),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_rd(mem_rd), .mem_data(mem_data),
    .we(we), .wr_addr(wr_addr), .wr_data(wr_data),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .fwd_hit_0(fwd_hit_0), .fwd_hit_1(fwd_hit_1),
    .fwd_data_0(fwd_data_0), .fwd_data_1(fwd_data_1)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0; iss_valid = 1'b0; iss_rd = 5'd0;
    ex_valid = 1'b1; ex_rd = 5'd5; ex_data = 64'hDEAD_BEEF;
    mem_valid = 1'b0; mem_rd = 5'd0; mem_data = 64'd0;
    rs1_addr = 5'd4; rs2_addr = 5'd0;
    step(); step();
    chk("rst_ex_ready", 64'(ex_ready), 64'd0);
    chk("rst_we", 64'(we), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_fwd", 64'(fwd_hit_1), 64'd0);

    // single write
    rst = 1'b1; #1;
    chk("single_ready", 64'(ex_ready), 64'd1);
    step(); ex_valid = 1'b0;
    chk("single_we", 64'(we), 64'd1);
    chk("single_addr", 64'(wr_addr), 64'd5);
    chk("single_data", wr_data, 64'hDEAD_BEEF);
    step();
    chk("idle_we", 64'(we), 64'd0);
    chk("idle_addr_hold", 64'(wr_addr), 64'd5);

    // conflict on same rd: mem first, then ex
    ex_valid = 1'b1; ex_rd = 5'd3; ex_data = 64'd1;
    mem_valid = 1'b1; mem_rd = 5'd3; mem_data = 64'd2; #1;
    chk("conf_mem_ready", 64'(mem_ready), 64'd1);
    chk("conf_ex_ready", 64'(ex_ready), 64'd0);
    step(); mem_valid = 1'b0;
    chk("conf1_data", wr_data, 64'd2);
    chk("conf1_addr", 64'(wr_addr), 64'd3);
    chk("conf2_ex_ready", 64'(ex_ready), 64'd1);
    step(); ex_valid = 1'b0;
    chk("conf2_we", 64'(we), 64'd1);
    chk("conf2_final", wr_data, 64'd1);

    // x0 target
    mem_valid = 1'b1; mem_rd = 5'd0; mem_data = 64'd77; #1;
    chk("x0_ready", 64'(mem_ready), 64'd1);
    step(); mem_valid = 1'b0;
    chk("x0_we", 64'(we), 64'd0);
    chk("x0_busy", 64'(busy), 64'd0);

    // scoreboard
    iss_valid = 1'b1; iss_rd = 5'd7;
    step();
    chk("sb_set", 64'(busy), 64'h80);
    ex_valid = 1'b1; ex_rd = 5'd7; ex_data = 64'h70; #1;
    chk("sb_ex_ready", 64'(ex_ready), 64'd1);
    step(); iss_valid = 1'b0;
    chk("sb_set_wins", 64'(busy), 64'h80);
    chk("sb_wr_addr", 64'(wr_addr), 64'd7);
    step(); ex_valid = 1'b0;
    chk("sb_clear", 64'(busy), 64'h0);

    // forwarding
    rs2_addr = 5'd9; ex_valid = 1'b1; ex_rd = 5'd9; ex_data = 64'h55;
    step(); ex_valid = 1'b0;
`ifdef REGFILE_WB_FWD_EN
    chk("fwd_hit_1", 64'(fwd_hit_1), 64'd1);
    chk("fwd_data_1", fwd_data_1, 64'h55);
`else
    chk("fwd_hit_1", 64'(fwd_hit_1), 64'd0);
    chk("fwd_data_1", fwd_data_1, 64'd0);
`endif
    chk("fwd_hit_0", 64'(fwd_hit_0), 64'd0);

    // reset mid-operation drops the granted write and clears the scoreboard
    iss_valid = 1'b1; iss_rd = 5'd12;
    step(); iss_valid = 1'b0;
    chk("mid_busy_set", 64'(busy), 64'h1000);
    ex_valid = 1'b1; ex_rd = 5'd12; ex_data = 64'hAB; rst = 1'b0; #1;
    chk("mid_ready", 64'(ex_ready), 64'd0);
    step();
    chk("mid_we", 64'(we), 64'd0);
    chk("mid_busy", 64'(busy), 64'd0);
    chk("mid_addr", 64'(wr_addr), 64'd0);
    rst = 1'b1; ex_valid = 1'b0;
    step();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
